// File: rtl/branch_predictor.sv
// Tournament branch predictor: bimodal + gshare tables, a chooser table, and a 4-bit GHR.
// Latency: predictions are combinational from current state; table/GHR updates land one edge later.
// Backpressure: none; an update is accepted on every cycle that upd_valid is high.
module branch_predictor (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst,
  input  logic [31:0] pc,
  output logic        predict1,
  output logic        predict2,
  output logic        prediction,
  output logic [3:0]  ghr_snap,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic [3:0]  upd_ghr,
  input  logic        upd_actual,
  input  logic        miss1,
  input  logic        miss2
);

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  logic [1:0] bim_q [16];
  logic [1:0] bim_d [16];
  logic [1:0] gsh_q [16];
  logic [1:0] gsh_d [16];
  logic [1:0] cho_q [16];
  logic [1:0] cho_d [16];
  logic [3:0] ghr_q;
  logic [3:0] ghr_d;

  logic [3:0] idx;
  logic [3:0] gidx;
  logic [3:0] upd_idx;
  logic [3:0] upd_gidx;
  logic       is_branch;
  logic       p1;
  logic       p2;

  // Only the word-index bits of each PC and the opcode field of inst matter here.
  logic unused_bits;
  assign unused_bits = ^{inst[31:7], pc[31:6], pc[1:0], upd_pc[31:6], upd_pc[1:0]};

  // 2-bit counter step that holds at the rails instead of wrapping.
  function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic up);
    if (up) begin
      return (cnt == 2'd3) ? cnt : cnt + 2'd1;
    end
    return (cnt == 2'd0) ? cnt : cnt - 2'd1;
  endfunction

  assign idx       = pc[5:2];
  assign gidx      = pc[5:2] ^ ghr_q;
  assign upd_idx   = upd_pc[5:2];
  assign upd_gidx  = upd_pc[5:2] ^ upd_ghr;
  assign is_branch = (inst[6:0] == OPC_BRANCH);

  // Fetch-side lookup from pre-update state; non-branches never predict taken.
  always_comb begin
    p1         = bim_q[idx][1];
    p2         = gsh_q[gidx][1];
    predict1   = is_branch & p1;
    predict2   = is_branch & p2;
    prediction = is_branch & (cho_q[idx][1] ? p2 : p1);
    ghr_snap   = ghr_q;
  end

  // Resolve-side training; GHR is rebuilt from the snapshot that travelled with the branch.
  always_comb begin
    bim_d = bim_q;
    gsh_d = gsh_q;
    cho_d = cho_q;
    ghr_d = ghr_q;
    if (upd_valid) begin
      bim_d[upd_idx]  = sat_step(bim_q[upd_idx], upd_actual);
      gsh_d[upd_gidx] = sat_step(gsh_q[upd_gidx], upd_actual);
      // Chooser only moves when exactly one predictor was wrong; miss1 pushes toward gshare.
      if (miss1 != miss2) begin
        cho_d[upd_idx] = sat_step(cho_q[upd_idx], miss1);
      end
      ghr_d = {upd_ghr[2:0], upd_actual};
    end
  end

  // State registers; reset leaves every counter weakly not-taken / weakly bimodal.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        bim_q[i] <= 2'b01;
        gsh_q[i] <= 2'b01;
        cho_q[i] <= 2'b01;
      end
      ghr_q <= 4'b0000;
    end else begin
      bim_q <= bim_d;
      gsh_q <= gsh_d;
      cho_q <= cho_d;
      ghr_q <= ghr_d;
    end
  end

endmodule
